// File: rtl/cl_lvds_tx_ser_pkg.sv
// rtl/cl_lvds_tx_ser_pkg.sv - shared constants, types and helpers for the Camera Link LVDS serializer
package cl_lvds_tx_ser_pkg;

  // Width of the saturating underflow counter and its ceiling
  localparam int UF_CNT_W = 16;
  localparam logic [UF_CNT_W-1:0] UF_CNT_MAX = '1;

  // Camera Link forwarded-clock shape for the usual 7:1 ratio (four high, three low, rotated)
  localparam logic [6:0] DEF_CLK_PATTERN = 7'b1100011;

  // Filler policy applied to a frame boundary that passes without an accepted word
  typedef enum logic {
    FILL_IDLE_WORD   = 1'b0,
    FILL_REPEAT_LAST = 1'b1
  } idle_mode_e;

  // Phase counter width; a ratio of two still needs one bit
  function automatic int ph_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/cl_lvds_tx_lane.sv
// rtl/cl_lvds_tx_lane.sv - one serializer lane: shift register, output bit register, true/complement pair
module cl_lvds_tx_lane #(
  parameter int             W          = 7,
  parameter logic           INV        = 1'b0,
  parameter logic [W-1:0]   RESET_WORD = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_word,
  output logic         o_p,
  output logic         o_n
);

  // r_shift holds the bits still waiting to go out, MSB-aligned
  logic [W-1:0] r_shift;
  logic         r_bit;
  logic         w_pin;

  // Load a fresh word at the frame boundary, otherwise shift the next bit onto the pin register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shift <= RESET_WORD;
      r_bit   <= 1'b0;
    end else if (i_en) begin
      if (i_load) begin
        r_bit   <= i_word[W-1];
        r_shift <= {i_word[W-2:0], 1'b0};
      end else begin
        r_bit   <= r_shift[W-1];
        r_shift <= {r_shift[W-2:0], 1'b0};
      end
    end
  end

  // Polarity swap is a constant XOR so a pair wired backwards on the board can be corrected here
  assign w_pin = r_bit ^ INV;
  assign o_p   = w_pin;
  assign o_n   = ~w_pin;

endmodule

// File: rtl/cl_lvds_tx_ser.sv
// rtl/cl_lvds_tx_ser.sv - multi-lane N:1 Camera Link transmit serializer with forwarded frame clock
module cl_lvds_tx_ser
  import cl_lvds_tx_ser_pkg::*;
#(
  parameter int                       NUM_LANES   = 4,
  parameter int                       SER_RATIO   = 7,
  parameter logic [SER_RATIO-1:0]     CLK_PATTERN = SER_RATIO'(DEF_CLK_PATTERN),
  parameter int                       IDLE_MODE   = 0,
  parameter logic [SER_RATIO-1:0]     IDLE_WORD   = '0,
  parameter logic [NUM_LANES-1:0]     INV_MASK    = '0,
  parameter string                    IOSTANDARD  = "LVDS"
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           EN,
  input  logic [NUM_LANES*SER_RATIO-1:0] DATA_IN,
  input  logic                           DATA_VALID,
  output logic                           DATA_READY,
  output logic [NUM_LANES-1:0]           O,
  output logic [NUM_LANES-1:0]           OB,
  output logic                           CLK_O,
  output logic                           CLK_OB,
  output logic                           FRAME_SYNC,
  output logic                           UNDERFLOW,
  output logic [UF_CNT_W-1:0]            UNDERFLOW_CNT
);

  localparam int                      PH_W        = ph_width(SER_RATIO);
  localparam int                      WORD_W      = NUM_LANES * SER_RATIO;
  localparam logic [PH_W-1:0]         L_LAST_PH   = PH_W'(SER_RATIO - 1);
  localparam logic [WORD_W-1:0]       L_IDLE_REP  = {NUM_LANES{IDLE_WORD}};
  localparam idle_mode_e              L_FILL_MODE = (IDLE_MODE != 0) ? FILL_REPEAT_LAST : FILL_IDLE_WORD;
  localparam bit                      L_IOSTD_OK  = (IOSTANDARD == "LVDS")      ||
                                                    (IOSTANDARD == "MINI-LVDS") ||
                                                    (IOSTANDARD == "SUB-LVDS")  ||
                                                    (IOSTANDARD == "TMDS")      ||
                                                    (IOSTANDARD == "PPDS")      ||
                                                    (IOSTANDARD == "RSDS")      ||
                                                    (IOSTANDARD == "LVDS_18")   ||
                                                    (IOSTANDARD == "DEFAULT");

  // Refuse to build a configuration the pad ring or the lane logic cannot support
  if (!L_IOSTD_OK || SER_RATIO < 2 || SER_RATIO > 16 || NUM_LANES < 1 || NUM_LANES > 8) begin : g_bad_cfg
    $fatal(1, "%m: unsupported cl_lvds_tx_ser configuration (IOSTANDARD=%s SER_RATIO=%0d NUM_LANES=%0d)",
           IOSTANDARD, SER_RATIO, NUM_LANES);
  end

  logic [PH_W-1:0]     r_ph;
  logic [WORD_W-1:0]   r_last;
  logic                r_frame_sync;
  logic                r_underflow;
  logic [UF_CNT_W-1:0] r_uf_cnt;

  logic                w_wrap;
  logic                w_load;
  logic                w_xfer;
  logic [WORD_W-1:0]   w_fill;
  logic [WORD_W-1:0]   w_word;

  // Frame-boundary decode, handshake and selection of the word the lanes load next
  always_comb begin
    w_wrap     = (r_ph == L_LAST_PH);
    // Lanes load on every enabled boundary; RST inside the lanes overrides the load
    w_load     = EN & w_wrap;
    DATA_READY = EN & ~RST & w_wrap;
    w_xfer     = DATA_READY & DATA_VALID;
    w_fill     = (L_FILL_MODE == FILL_REPEAT_LAST) ? r_last : L_IDLE_REP;
    w_word     = w_xfer ? DATA_IN : w_fill;
  end

  // Bit-phase counter: one step per enabled cycle, wraps after the last bit of the frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ph <= '0;
    end else if (EN) begin
      r_ph <= w_wrap ? '0 : r_ph + PH_W'(1);
    end
  end

  // Remember the last accepted word so the repeat-last filler has something to replay
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last <= L_IDLE_REP;
    end else if (w_xfer) begin
      r_last <= DATA_IN;
    end
  end

  // Frame-start and underflow pulses, plus the saturating count of missed boundaries
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_frame_sync <= 1'b0;
      r_underflow  <= 1'b0;
      r_uf_cnt     <= '0;
    end else begin
      r_frame_sync <= w_load;
      r_underflow  <= w_load & ~w_xfer;
      if (w_load && !w_xfer && r_uf_cnt != UF_CNT_MAX) begin
        r_uf_cnt <= r_uf_cnt + UF_CNT_W'(1);
      end
    end
  end

  assign FRAME_SYNC    = r_frame_sync;
  assign UNDERFLOW     = r_underflow;
  assign UNDERFLOW_CNT = r_uf_cnt;

  // Data lanes, each with its own polarity setting
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    cl_lvds_tx_lane #(
      .W          (SER_RATIO),
      .INV        (INV_MASK[k]),
      .RESET_WORD (IDLE_WORD)
    ) u_lane (
      .CLK    (CLK),
      .RST    (RST),
      .i_en   (EN),
      .i_load (w_load),
      .i_word (w_word[k*SER_RATIO +: SER_RATIO]),
      .o_p    (O[k]),
      .o_n    (OB[k])
    );
  end

  // Forwarded clock lane reuses the data lane with a constant pattern so it stays phase-aligned
  cl_lvds_tx_lane #(
    .W          (SER_RATIO),
    .INV        (1'b0),
    .RESET_WORD (CLK_PATTERN)
  ) u_clk_lane (
    .CLK    (CLK),
    .RST    (RST),
    .i_en   (EN),
    .i_load (w_load),
    .i_word (CLK_PATTERN),
    .o_p    (CLK_O),
    .o_n    (CLK_OB)
  );

endmodule

// File: tb/tb_cl_lvds_tx_ser.sv
// tb/tb_cl_lvds_tx_ser.sv - randomized scoreboard bench for cl_lvds_tx_ser (7:1 x4 and 10:1 x2 builds)
module tb_cl_lvds_tx_ser;

  localparam int ND   = 2;
  localparam int SR_A = 7;
  localparam int NL_A = 4;
  localparam int SR_B = 10;
  localparam int NL_B = 2;
  localparam logic [6:0] CP_A  = 7'b1100011;
  localparam logic [9:0] CP_B  = 10'b1111100000;
  localparam logic [9:0] IW_B  = 10'h2A5;
  localparam logic [3:0] INV_A = 4'b0101;
  localparam logic [1:0] INV_B = 2'b10;

  int          sr_of   [ND] = '{SR_A, SR_B};
  int          nl_of   [ND] = '{NL_A, NL_B};
  bit          mode_of [ND] = '{1'b0, 1'b1};
  logic [15:0] idle_of [ND] = '{16'h0000, 16'h02A5};
  logic [7:0]  inv_of  [ND] = '{8'h05, 8'h02};
  logic [15:0] cpat_of [ND] = '{16'h0063, 16'h03E0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [31:0]   din [ND];
  logic [ND-1:0] val = '0;

  logic [27:0] din_a;
  logic [19:0] din_b;
  logic        rdy_a, clko_a, clkob_a, fs_a, uf_a;
  logic        rdy_b, clko_b, clkob_b, fs_b, uf_b;
  logic [3:0]  o_a, ob_a;
  logic [1:0]  o_b, ob_b;
  logic [15:0] cnt_a, cnt_b;

  logic [ND-1:0] rdy, clko, clkob, fs, uf;
  logic [7:0]    o   [ND];
  logic [7:0]    ob  [ND];
  logic [15:0]   cnt [ND];

  assign din_a  = din[0][27:0];
  assign din_b  = din[1][19:0];
  assign rdy    = {rdy_b, rdy_a};
  assign clko   = {clko_b, clko_a};
  assign clkob  = {clkob_b, clkob_a};
  assign fs     = {fs_b, fs_a};
  assign uf     = {uf_b, uf_a};
  assign o[0]   = {4'b0, o_a};
  assign o[1]   = {6'b0, o_b};
  assign ob[0]  = {4'b0, ob_a};
  assign ob[1]  = {6'b0, ob_b};
  assign cnt[0] = cnt_a;
  assign cnt[1] = cnt_b;

  cl_lvds_tx_ser #(
    .NUM_LANES(NL_A), .SER_RATIO(SR_A), .CLK_PATTERN(CP_A), .IDLE_MODE(0),
    .IDLE_WORD(7'h00), .INV_MASK(INV_A), .IOSTANDARD("LVDS")
  ) u_a (
    .CLK(clk), .RST(rst), .EN(en), .DATA_IN(din_a), .DATA_VALID(val[0]), .DATA_READY(rdy_a),
    .O(o_a), .OB(ob_a), .CLK_O(clko_a), .CLK_OB(clkob_a), .FRAME_SYNC(fs_a),
    .UNDERFLOW(uf_a), .UNDERFLOW_CNT(cnt_a)
  );

  cl_lvds_tx_ser #(
    .NUM_LANES(NL_B), .SER_RATIO(SR_B), .CLK_PATTERN(CP_B), .IDLE_MODE(1),
    .IDLE_WORD(IW_B), .INV_MASK(INV_B), .IOSTANDARD("TMDS")
  ) u_b (
    .CLK(clk), .RST(rst), .EN(en), .DATA_IN(din_b), .DATA_VALID(val[1]), .DATA_READY(rdy_b),
    .O(o_b), .OB(ob_b), .CLK_O(clko_b), .CLK_OB(clkob_b), .FRAME_SYNC(fs_b),
    .UNDERFLOW(uf_b), .UNDERFLOW_CNT(cnt_b)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int d, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h required %0h", nm, d, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    bit          uf;
    int          cnt;
  } frame_t;

  frame_t exp_q [ND][$];

  // Reference model state: enabled cycles since reset, last accepted word, underflow count
  int          m_ecnt [ND];
  logic [31:0] m_last [ND];
  int          m_cnt  [ND];
  bit          pend   [ND];

  function automatic logic [31:0] wmask(input int bits);
    return (32'h1 << bits) - 32'h1;
  endfunction

  function automatic logic [31:0] idle_rep(input int d);
    logic [31:0] rep = '0;
    for (int k = 0; k < nl_of[d]; k++) rep |= {16'h0, idle_of[d]} << (k * sr_of[d]);
    return rep;
  endfunction

  function automatic logic [15:0] lane_bits(input logic [31:0] w, input int d, input int k);
    return 16'((w >> (k * sr_of[d])) & wmask(sr_of[d]));
  endfunction

  // One cycle of stimulus: drive at the falling edge, check READY, then advance the model
  task automatic step(input bit r, input bit e, input int pval, input bit fixed_a);
    bit          exp_rdy;
    bit          xfer;
    logic [31:0] word;
    frame_t      f;
    @(negedge clk);
    rst = r;
    en  = e;
    for (int d = 0; d < ND; d++) begin
      if (!pend[d]) begin
        val[d] = ($urandom_range(99) < pval);
        din[d] = (fixed_a && d == 0 && val[d]) ? 32'h0ABCDEF : ($urandom & wmask(nl_of[d] * sr_of[d]));
        pend[d] = val[d];
      end
    end
    #1;
    for (int d = 0; d < ND; d++) begin
      exp_rdy = e && !r && (m_ecnt[d] % sr_of[d] == sr_of[d] - 1);
      chk("data_ready", d, 64'(rdy[d]), 64'(exp_rdy));
      if (r) begin
        m_ecnt[d] = 0;
        m_last[d] = idle_rep(d);
        m_cnt[d]  = 0;
      end else if (e) begin
        if (exp_rdy) begin
          xfer = val[d];
          word = xfer ? din[d] : (mode_of[d] ? m_last[d] : idle_rep(d));
          if (xfer) begin
            m_last[d] = din[d];
            pend[d]   = 1'b0;
          end else if (m_cnt[d] < 65535) begin
            m_cnt[d]++;
          end
          f.word = word;
          f.uf   = !xfer;
          f.cnt  = m_cnt[d];
          exp_q[d].push_back(f);
        end
        m_ecnt[d]++;
      end
    end
  endtask

  // Monitor state: bits gathered for the current frame (-1 = not inside a frame)
  int          nb     [ND] = '{-1, -1};
  logic [15:0] cap    [ND][8];
  logic [15:0] ccap   [ND];
  frame_t      cur    [ND];
  logic [7:0]  o_hold [ND];
  logic        c_hold [ND];

  // Monitor: sample just after each rising edge, reassemble frames from the pins, compare to queue
  always @(posedge clk) begin
    logic [7:0] lm;
    #1;
    for (int d = 0; d < ND; d++) begin
      lm = 8'((16'h1 << nl_of[d]) - 16'h1);
      chk("pair_complement", d, 64'({ob[d], clkob[d]}), 64'({~o[d] & lm, ~clko[d]}));
      if (rst) begin
        chk("rst_o", d, 64'(o[d]), 64'(inv_of[d]));
        chk("rst_clk_o", d, 64'(clko[d]), 64'(0));
        chk("rst_frame_sync", d, 64'(fs[d]), 64'(0));
        chk("rst_underflow", d, 64'(uf[d]), 64'(0));
        chk("rst_uf_cnt", d, 64'(cnt[d]), 64'(0));
        chk("rst_ready", d, 64'(rdy[d]), 64'(0));
        nb[d] = -1;
      end else if (en) begin
        if (fs[d]) begin
          if (nb[d] >= 0 && nb[d] < sr_of[d]) begin
            chk("frame_len", d, 64'(nb[d]), 64'(sr_of[d]));
          end
          if (exp_q[d].size() == 0) begin
            chk("unexpected_frame", d, 64'(1), 64'(0));
            nb[d] = -1;
          end else begin
            cur[d] = exp_q[d].pop_front();
            chk("underflow", d, 64'(uf[d]), 64'(cur[d].uf));
            chk("uf_cnt", d, 64'(cnt[d]), 64'(cur[d].cnt));
            for (int k = 0; k < nl_of[d]; k++) cap[d][k] = {15'b0, o[d][k] ^ inv_of[d][k]};
            ccap[d] = {15'b0, clko[d]};
            nb[d]   = 1;
          end
        end else begin
          chk("underflow_off_boundary", d, 64'(uf[d]), 64'(0));
          if (nb[d] >= sr_of[d]) begin
            chk("frame_sync_missing", d, 64'(0), 64'(1));
            nb[d] = -1;
          end else if (nb[d] >= 0) begin
            for (int k = 0; k < nl_of[d]; k++) cap[d][k] = {cap[d][k][14:0], o[d][k] ^ inv_of[d][k]};
            ccap[d] = {ccap[d][14:0], clko[d]};
            nb[d]++;
          end
        end
        if (nb[d] == sr_of[d]) begin
          for (int k = 0; k < nl_of[d]; k++) begin
            chk($sformatf("lane%0d_bits", k), d, 64'(cap[d][k]), 64'(lane_bits(cur[d].word, d, k)));
          end
          chk("clk_lane_bits", d, 64'(ccap[d]), 64'(cpat_of[d]));
        end
      end else begin
        chk("frozen_pins", d, 64'({o[d], clko[d]}), 64'({o_hold[d], c_hold[d]}));
      end
      o_hold[d] = o[d];
      c_hold[d] = clko[d];
    end
  end

  initial begin
    bit rr;
    bit ee;
    for (int d = 0; d < ND; d++) begin
      din[d]    = '0;
      pend[d]   = 1'b0;
      m_ecnt[d] = 0;
      m_last[d] = idle_rep(d);
      m_cnt[d]  = 0;
    end
    repeat (3) step(1'b1, 1'b1, 0, 1'b0);
    // Continuous fixed word on the 7:1 build, continuous random on the 10:1 build
    repeat (40) step(1'b0, 1'b1, 100, 1'b1);
    // Source starves: filler frames and underflow counting
    repeat (25) step(1'b0, 1'b1, 0, 1'b0);
    repeat (20) step(1'b0, 1'b1, 100, 1'b0);
    // EN dropped for five cycles in the middle of a frame
    while (m_ecnt[0] % SR_A != 3) step(1'b0, 1'b1, 100, 1'b0);
    repeat (5) step(1'b0, 1'b0, 100, 1'b0);
    repeat (30) step(1'b0, 1'b1, 100, 1'b0);
    // Reset in the middle of a frame
    while (m_ecnt[0] % SR_A != 3) step(1'b0, 1'b1, 100, 1'b0);
    step(1'b1, 1'b1, 100, 1'b0);
    repeat (20) step(1'b0, 1'b1, 100, 1'b0);
    // Reset on the boundary cycle with a word offered
    while (m_ecnt[0] % SR_A != SR_A - 1) step(1'b0, 1'b1, 100, 1'b0);
    step(1'b1, 1'b1, 100, 1'b0);
    // Random traffic, enable gaps and occasional resets
    repeat (600) begin
      rr = ($urandom_range(249) == 0);
      ee = ($urandom_range(99) < 85);
      step(rr, ee, 50, 1'b0);
    end
    // Counter saturation: preload near the ceiling between boundaries, then starve
    while (m_ecnt[0] % SR_A != 2) step(1'b0, 1'b1, 0, 1'b0);
    force u_a.r_uf_cnt = 16'hFFFD;
    #1;
    release u_a.r_uf_cnt;
    m_cnt[0] = 32'hFFFD;
    repeat (45) step(1'b0, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0);
    @(posedge clk);
    #2;
    for (int d = 0; d < ND; d++) chk("frames_all_seen", d, 64'(exp_q[d].size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
